// File: rtl/i2c_init_sequencer_if.sv
// Transaction interface between the init sequencer and the I2C master.
// The sequencer uses the master modport; the I2C master side uses slave.
interface i2c_init_sequencer_if;
  logic       m_valid;
  logic       m_ready;
  logic [6:0] m_dev;
  logic [7:0] m_reg;
  logic [7:0] m_wdata;
  logic       m_rw;
  logic       m_done;
  logic       m_nack;
  logic [7:0] m_rdata;

  modport master (
    output m_valid, m_dev, m_reg, m_wdata, m_rw,
    input  m_ready, m_done, m_nack, m_rdata
  );

  modport slave (
    input  m_valid, m_dev, m_reg, m_wdata, m_rw,
    output m_ready, m_done, m_nack, m_rdata
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// Walks a loadable table of I2C register writes, one transaction at a time, with NACK retries.
// Define I2C_INIT_READBACK_VERIFY_EN to read back and compare every write before advancing.
module i2c_init_sequencer #(
  parameter int AW         = 4,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic                 hwclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW:0]          num_entries,
  input  logic                 tbl_we,
  input  logic [AW-1:0]        tbl_waddr,
  input  logic [22:0]          tbl_wdata,
  i2c_init_sequencer_if.master m,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [AW-1:0]        err_index
);
`ifdef I2C_INIT_READBACK_VERIFY_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(2**AW);
  localparam logic [AW:0]   IDX_ONE   = (AW+1)'(1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_ONE = RW'(1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, GAP, FINISH} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [AW-1:0] err_index_q, err_index_d;
  logic          valid_q, valid_d;
  logic          rw_q, rw_d;
  logic [AW:0]   num_q, num_d;
  logic [AW:0]   idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          gap_fetch_q, gap_fetch_d;
  logic          rd_next_q, rd_next_d;

  logic [22:0]   tbl_mem [2**AW];
  logic [22:0]   entry_q;
  logic          fetch;
  logic [AW:0]   num_clamped;
  logic [AW:0]   idx_inc;

  // Table is frozen while a sequence runs so retries can reuse entry_q safely.
  always_ff @(posedge hwclk) begin
    if (tbl_we && !busy_q) begin
      tbl_mem[tbl_waddr] <= tbl_wdata;
    end
  end

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else if (fetch) begin
      entry_q <= tbl_mem[idx_q[AW-1:0]];
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_index_d = err_index_q;
    valid_d     = valid_q;
    rw_d        = rw_q;
    num_d       = num_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    gap_fetch_d = gap_fetch_q;
    rd_next_d   = rd_next_q;
    fetch       = 1'b0;
    num_clamped = (num_entries > DEPTH) ? DEPTH : num_entries;
    idx_inc     = idx_q + IDX_ONE;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          error_d = 1'b0;
          num_d   = num_clamped;
          idx_d   = '0;
          retry_d = '0;
          rw_d    = 1'b0;
          state_d = (num_clamped == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        fetch   = 1'b1;
        valid_d = 1'b1;
        rw_d    = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (m.m_ready) begin
          valid_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m.m_done) begin
          gap_d = GAP_LAST;
          if (RB_EN && !rw_q && !m.m_nack) begin
            state_d     = GAP;
            gap_fetch_d = 1'b0;
            rd_next_d   = 1'b1;
          end else if (!m.m_nack && (!rw_q || m.m_rdata == entry_q[7:0])) begin
            retry_d   = '0;
            idx_d     = idx_inc;
            rd_next_d = 1'b0;
            if (idx_inc == num_q) begin
              state_d = FINISH;
            end else begin
              state_d     = GAP;
              gap_fetch_d = 1'b1;
            end
          end else if (retry_q < RETRY_MAX) begin
            // A failed readback also restarts from the write.
            retry_d     = retry_q + RETRY_ONE;
            state_d     = GAP;
            gap_fetch_d = 1'b0;
            rd_next_d   = 1'b0;
          end else begin
            error_d     = 1'b1;
            err_index_d = idx_q[AW-1:0];
            state_d     = FINISH;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (gap_fetch_q) begin
            state_d = FETCH;
          end else begin
            state_d = ISSUE;
            valid_d = 1'b1;
            rw_d    = rd_next_q;
          end
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      valid_q     <= 1'b0;
      rw_q        <= 1'b0;
      num_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      gap_q       <= '0;
      gap_fetch_q <= 1'b0;
      rd_next_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      valid_q     <= valid_d;
      rw_q        <= rw_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
      gap_fetch_q <= gap_fetch_d;
      rd_next_q   <= rd_next_d;
    end
  end

  assign m.m_valid = valid_q;
  assign m.m_dev   = entry_q[22:16];
  assign m.m_reg   = entry_q[15:8];
  assign m.m_wdata = rw_q ? 8'h00 : entry_q[7:0];
  assign m.m_rw    = rw_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed self-checking bench for i2c_init_sequencer with a scripted I2C master model.
`timescale 1ns/1ps
module tb_i2c_init_sequencer;
  localparam int AW   = 4;
  localparam int GAP  = 16;
  localparam int MAXR = 3;
  localparam logic [22:0] E0 = {7'h3C, 8'h00, 8'hAE};
  localparam logic [22:0] E1 = {7'h3C, 8'h01, 8'h55};
  localparam logic [22:0] E2 = {7'h3C, 8'h02, 8'hFF};

  logic          hwclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_entries = '0;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_waddr = '0;
  logic [22:0]   tbl_wdata = '0;
  logic          busy, done, error;
  logic [AW-1:0] err_index;
  int            total = 0;
  int            bad = 0;
  int            acc = 0;

  i2c_init_sequencer_if mif();

  i2c_init_sequencer #(.AW(AW), .GAP_CYCLES(GAP), .MAX_RETRY(MAXR)) dut (
    .hwclk(hwclk), .rst_n(rst_n), .start(start), .num_entries(num_entries),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata), .m(mif),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  always #5 hwclk = ~hwclk;

  // Independent count of handshakes the master actually accepted.
  always @(posedge hwclk) if (mif.m_valid && mif.m_ready) acc <= acc + 1;

  task automatic tick();
    @(posedge hwclk); #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [22:0] d);
    tbl_we = 1'b1; tbl_waddr = a; tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic kick(input logic [AW:0] n);
    start = 1'b1; num_entries = n;
    tick();
    start = 1'b0;
  endtask

  // Master model: waits for a request, holds ready low, accepts, then reports done/nack.
  task automatic serve(input int hold, input bit nack, input logic [7:0] rdata,
                       output logic [22:0] pay, output logic rw, output int n, output bit stable);
    n = 0;
    while (!mif.m_valid && n < 200) begin tick(); n++; end
    if (!mif.m_valid) begin pay = '1; rw = 1'bx; n = -1; stable = 1'b0; return; end
    pay = {mif.m_dev, mif.m_reg, mif.m_wdata}; rw = mif.m_rw; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!mif.m_valid || {mif.m_dev, mif.m_reg, mif.m_wdata} !== pay || mif.m_rw !== rw) stable = 1'b0;
    end
    mif.m_ready = 1'b1; tick(); mif.m_ready = 1'b0;
    if (mif.m_valid) stable = 1'b0;
    tick();
    mif.m_done = 1'b1; mif.m_nack = nack; mif.m_rdata = rdata;
    tick();
    mif.m_done = 1'b0; mif.m_nack = 1'b0; mif.m_rdata = '0;
    $display("txn dev=%h reg=%h wdata=%h rw=%0d nack=%0d rdata=%h wait=%0d",
             pay[22:16], pay[15:8], pay[7:0], rw, nack, rdata, n);
  endtask

  task automatic watch(input int cycles, output int first_done, output int n_done,
                       output logic busy_at_done, output logic busy_pre, output int n_valid);
    logic prev_busy;
    first_done = -1; n_done = 0; n_valid = 0; busy_at_done = 1'bx; busy_pre = 1'bx;
    prev_busy = busy;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (mif.m_valid) n_valid++;
      if (done) begin
        n_done++;
        if (first_done < 0) begin first_done = i + 1; busy_at_done = busy; busy_pre = prev_busy; end
      end
      prev_busy = busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    total++; if ({mif.m_valid, busy, done, error, mif.m_rw} !== 5'b0) begin bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {mif.m_valid, busy, done, error, mif.m_rw}); end
    total++; if ({mif.m_dev, mif.m_reg, mif.m_wdata} !== 23'h0) begin bad++;
      $display("FAIL reset_payload: got %h want 0", {mif.m_dev, mif.m_reg, mif.m_wdata}); end
    total++; if (err_index !== '0) begin bad++; $display("FAIL reset_err_index: got %0d want 0", err_index); end
    rst_n = 1'b1; tick();
  endtask

`ifdef I2C_INIT_READBACK_VERIFY_EN
  task automatic test_readback();
    logic [22:0] p; logic rw; int n, fd, nd, nv; bit st; logic bd, bp;
    load(0, E0); load(1, E1);
    kick(2);
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if ({p, rw} !== {E0, 1'b0}) begin bad++; $display("FAIL rb_w0: got %h/%0d want %h/0", p, rw, E0); end
    serve(0, 1'b0, 8'hAE, p, rw, n, st);
    total++; if ({p, rw} !== {7'h3C, 8'h00, 8'h00, 1'b1}) begin bad++; $display("FAIL rb_r0: got %h/%0d want 3c0000/1", p, rw); end
    total++; if (n !== GAP) begin bad++; $display("FAIL rb_gap: got %0d want %0d", n, GAP); end
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if ({p, rw} !== {E1, 1'b0}) begin bad++; $display("FAIL rb_w1: got %h/%0d want %h/0", p, rw, E1); end
    serve(0, 1'b0, 8'h54, p, rw, n, st);
    total++; if ({p, rw} !== {7'h3C, 8'h01, 8'h00, 1'b1}) begin bad++; $display("FAIL rb_r1: got %h/%0d want 3c0100/1", p, rw); end
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if ({p, rw, n} !== {E1, 1'b0, GAP}) begin bad++; $display("FAIL rb_retry_w1: got %h/%0d/%0d want %h/0/%0d", p, rw, n, E1, GAP); end
    serve(0, 1'b0, 8'h55, p, rw, n, st);
    total++; if ({p, rw} !== {7'h3C, 8'h01, 8'h00, 1'b1}) begin bad++; $display("FAIL rb_retry_r1: got %h/%0d want 3c0100/1", p, rw); end
    watch(30, fd, nd, bd, bp, nv);
    total++; if ({fd, nd, nv} !== {32'd1, 32'd1, 32'd0}) begin bad++; $display("FAIL rb_done: got first=%0d n=%0d valid=%0d want 1/1/0", fd, nd, nv); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rb_error: got %b want 0", error); end
  endtask
`else
  task automatic test_basic();
    logic [22:0] p; logic rw; int n, fd, nd, nv, acc0; bit st; logic bd, bp;
    load(0, E0); load(1, E1); load(2, E2);
    acc0 = acc;
    kick(3);
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    // kick consumed one edge, so n = 1 means valid rose two edges after start was driven.
    total++; if (n !== 1) begin bad++; $display("FAIL basic_latency: got %0d want 1", n); end
    total++; if ({p, rw} !== {E0, 1'b0}) begin bad++; $display("FAIL basic_e0: got %h/%0d want %h/0", p, rw, E0); end
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if (p !== E1) begin bad++; $display("FAIL basic_e1: got %h want %h", p, E1); end
    total++; if (n !== GAP + 1) begin bad++; $display("FAIL basic_gap: got %0d want %0d", n, GAP + 1); end
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if ({p, rw} !== {E2, 1'b0}) begin bad++; $display("FAIL basic_e2: got %h/%0d want %h/0", p, rw, E2); end
    watch(30, fd, nd, bd, bp, nv);
    total++; if ({fd, nd} !== {32'd1, 32'd1}) begin bad++; $display("FAIL basic_done: got first=%0d n=%0d want 1/1", fd, nd); end
    total++; if ({bp, bd} !== 2'b10) begin bad++; $display("FAIL basic_busy_fall: got %b want 10", {bp, bd}); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", error); end
    total++; if (acc - acc0 !== 3) begin bad++; $display("FAIL basic_accepts: got %0d want 3", acc - acc0); end
  endtask

  task automatic test_hold();
    logic [22:0] p; logic rw; int n, fd, nd, nv, acc0; bit st; logic bd, bp;
    acc0 = acc;
    kick(1);
    serve(10, 1'b0, 8'h00, p, rw, n, st);
    total++; if (st !== 1'b1) begin bad++; $display("FAIL hold_stable: got %0d want 1", st); end
    total++; if (p !== E0) begin bad++; $display("FAIL hold_payload: got %h want %h", p, E0); end
    watch(5, fd, nd, bd, bp, nv);
    total++; if (acc - acc0 !== 1) begin bad++; $display("FAIL hold_accepts: got %0d want 1", acc - acc0); end
    total++; if (nd !== 1) begin bad++; $display("FAIL hold_done: got %0d want 1", nd); end
  endtask

  task automatic test_nack_retry();
    logic [22:0] p; logic rw; int n, fd, nd, nv; bit st; logic bd, bp;
    kick(3);
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    serve(0, 1'b1, 8'h00, p, rw, n, st);
    total++; if (p !== E1) begin bad++; $display("FAIL retry_try1: got %h want %h", p, E1); end
    serve(0, 1'b1, 8'h00, p, rw, n, st);
    total++; if ({p, n} !== {E1, GAP}) begin bad++; $display("FAIL retry_try2: got %h/%0d want %h/%0d", p, n, E1, GAP); end
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if ({p, n} !== {E1, GAP}) begin bad++; $display("FAIL retry_try3: got %h/%0d want %h/%0d", p, n, E1, GAP); end
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if (p !== E2) begin bad++; $display("FAIL retry_e2: got %h want %h", p, E2); end
    watch(30, fd, nd, bd, bp, nv);
    total++; if ({nd, error} !== {32'd1, 1'b0}) begin bad++; $display("FAIL retry_end: got done=%0d err=%b want 1/0", nd, error); end
  endtask

  task automatic test_fail();
    logic [22:0] p; logic rw; int n, fd, nd, nv; bit st; logic bd, bp;
    kick(3);
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    for (int i = 0; i < MAXR + 1; i++) begin
      serve(0, 1'b1, 8'h00, p, rw, n, st);
      total++; if (p !== E1) begin bad++; $display("FAIL fail_attempt%0d: got %h want %h", i, p, E1); end
    end
    watch(40, fd, nd, bd, bp, nv);
    total++; if ({fd, nd, nv} !== {32'd1, 32'd1, 32'd0}) begin bad++; $display("FAIL fail_done: got first=%0d n=%0d valid=%0d want 1/1/0", fd, nd, nv); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL fail_error: got %b want 1", error); end
    total++; if (err_index !== 4'd1) begin bad++; $display("FAIL fail_err_index: got %0d want 1", err_index); end
    kick(1);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL fail_error_clear: got %b want 0", error); end
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    watch(5, fd, nd, bd, bp, nv);
    total++; if (nd !== 1) begin bad++; $display("FAIL fail_rerun_done: got %0d want 1", nd); end
  endtask

  task automatic test_zero_and_ignored();
    logic [22:0] p; logic rw; int n, fd, nd, nv; bit st; logic bd, bp;
    kick(0);
    watch(6, fd, nd, bd, bp, nv);
    total++; if ({fd, nd, nv} !== {32'd1, 32'd1, 32'd0}) begin bad++; $display("FAIL zero_done: got first=%0d n=%0d valid=%0d want 1/1/0", fd, nd, nv); end
    kick(2);
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    start = 1'b1; num_entries = 3; tbl_we = 1'b1; tbl_waddr = 1; tbl_wdata = 23'h7FFFFF;
    tick();
    start = 1'b0; tbl_we = 1'b0;
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if ({p, n} !== {E1, GAP}) begin bad++; $display("FAIL ignored_write: got %h/%0d want %h/%0d", p, n, E1, GAP); end
    watch(40, fd, nd, bd, bp, nv);
    total++; if ({nd, nv} !== {32'd1, 32'd0}) begin bad++; $display("FAIL ignored_start: got done=%0d valid=%0d want 1/0", nd, nv); end
  endtask

  task automatic test_reset_mid();
    logic [22:0] p; logic rw; int n, fd, nd, nv; bit st; logic bd, bp;
    kick(3);
    n = 0;
    while (!mif.m_valid && n < 50) begin tick(); n++; end
    mif.m_ready = 1'b1; tick(); mif.m_ready = 1'b0;
    rst_n = 1'b0; tick();
    total++; if ({mif.m_valid, busy, done, error, mif.m_rw} !== 5'b0) begin bad++;
      $display("FAIL midrst_ctrl: got %b want 00000", {mif.m_valid, busy, done, error, mif.m_rw}); end
    total++; if ({mif.m_dev, mif.m_reg, mif.m_wdata} !== 23'h0) begin bad++;
      $display("FAIL midrst_payload: got %h want 0", {mif.m_dev, mif.m_reg, mif.m_wdata}); end
    rst_n = 1'b1; mif.m_done = 1'b1; tick(); mif.m_done = 1'b0;
    watch(20, fd, nd, bd, bp, nv);
    total++; if ({nd, nv, busy} !== {32'd0, 32'd0, 1'b0}) begin bad++; $display("FAIL midrst_late_done: got done=%0d valid=%0d busy=%b want 0/0/0", nd, nv, busy); end
    kick(3);
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if (p !== E0) begin bad++; $display("FAIL midrst_e0: got %h want %h", p, E0); end
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if (p !== E1) begin bad++; $display("FAIL midrst_e1: got %h want %h", p, E1); end
    serve(0, 1'b0, 8'h00, p, rw, n, st);
    total++; if (p !== E2) begin bad++; $display("FAIL midrst_e2: got %h want %h", p, E2); end
    watch(10, fd, nd, bd, bp, nv);
    total++; if (nd !== 1) begin bad++; $display("FAIL midrst_done: got %0d want 1", nd); end
  endtask
`endif

  initial begin
    mif.m_ready = 1'b0; mif.m_done = 1'b0; mif.m_nack = 1'b0; mif.m_rdata = '0;
    test_reset();
`ifdef I2C_INIT_READBACK_VERIFY_EN
    test_readback();
`else
    test_basic();
    test_hold();
    test_nack_retry();
    test_fail();
    test_zero_and_ignored();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
